// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register outstanding-write counters gate instruction issue.
// Latency: issue_ready is combinational; counters, mask and total update one cycle after issue or writeback.
// Backpressure: issue_ready drops while a source has a write in flight or the destination counter is saturated.
module reg_scoreboard #(
  parameter int MAX_OUT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_use1,
  input  logic [4:0]  issue_ra1,
  input  logic        issue_use2,
  input  logic [4:0]  issue_ra2,
  input  logic        issue_we,
  input  logic [4:0]  issue_wa,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_wa,
  output logic [31:0] pending_mask,
  output logic [7:0]  total_out,
  output logic        err_underflow
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

  // Entry 0 exists only to keep indexing uniform; it is held at zero.
  logic [2:0]  cnt     [32];
  logic [2:0]  cnt_nxt [32];
  logic [31:0] inc_vec;
  logic [31:0] wb_vec;
  logic [31:0] mask_nxt;
  logic [7:0]  total_nxt;
  logic        src1_haz;
  logic        src2_haz;
  logic        dst_full;
  logic        accept;
  logic        underflow;

  assign src1_haz    = issue_use1 && (issue_ra1 != 5'd0) && (cnt[issue_ra1] != 3'd0);
  assign src2_haz    = issue_use2 && (issue_ra2 != 5'd0) && (cnt[issue_ra2] != 3'd0);
  assign dst_full    = issue_we && (issue_wa != 5'd0) && (cnt[issue_wa] == MAX_CNT);
  assign issue_ready = !(src1_haz || src2_haz || dst_full);
  assign accept      = issue_valid && issue_ready && !rst;
  // Underflow judged on the pre-update count, even if an issue to the same register lands this cycle.
  assign underflow   = wb_valid && !rst && (wb_wa != 5'd0) && (cnt[wb_wa] == 3'd0);

  // Decode which counter the accepted issue and the writeback touch.
  always_comb begin
    inc_vec = '0;
    wb_vec  = '0;
    for (int i = 1; i < 32; i++) begin
      inc_vec[i] = accept && issue_we && (issue_wa == 5'(i));
      wb_vec[i]  = wb_valid && !rst && (wb_wa == 5'(i));
    end
  end

  // Next-state counters plus the derived mask and total that are registered alongside them.
  always_comb begin
    mask_nxt  = '0;
    total_nxt = '0;
    cnt_nxt[0] = 3'd0;
    for (int i = 1; i < 32; i++) begin
      cnt_nxt[i] = cnt[i];
      if (inc_vec[i] && wb_vec[i]) begin
        cnt_nxt[i] = cnt[i];
      end else if (inc_vec[i]) begin
        cnt_nxt[i] = cnt[i] + 3'd1;
      end else if (wb_vec[i] && (cnt[i] != 3'd0)) begin
        cnt_nxt[i] = cnt[i] - 3'd1;
      end
      mask_nxt[i] = (cnt_nxt[i] != 3'd0);
      total_nxt   = total_nxt + {5'd0, cnt_nxt[i]};
    end
  end

  // State update; synchronous reset discards every outstanding write and the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= 3'd0;
      end
      pending_mask  <= '0;
      total_out     <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      pending_mask <= mask_nxt;
      total_out    <= total_nxt;
      if (underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: vector table plus a stall-latency sequence.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Each vector checks issue_ready pre-edge and the registered outputs post-edge.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_use1;
  logic [4:0]  issue_ra1;
  logic        issue_use2;
  logic [4:0]  issue_ra2;
  logic        issue_we;
  logic [4:0]  issue_wa;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_wa;
  logic [31:0] pending_mask;
  logic [7:0]  total_out;
  logic        err_underflow;

  int errors = 0;
  int checks = 0;

  reg_scoreboard #(.MAX_OUT(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_use1(issue_use1), .issue_ra1(issue_ra1),
    .issue_use2(issue_use2), .issue_ra2(issue_ra2),
    .issue_we(issue_we), .issue_wa(issue_wa), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_wa(wb_wa),
    .pending_mask(pending_mask), .total_out(total_out), .err_underflow(err_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        v;
    logic        u1;
    logic [4:0]  ra1;
    logic        u2;
    logic [4:0]  ra2;
    logic        we;
    logic [4:0]  wa;
    logic        wbv;
    logic [4:0]  wbwa;
    logic        e_ready;
    logic [31:0] e_mask;
    logic [7:0]  e_total;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, logic u1, logic [4:0] ra1, logic u2, logic [4:0] ra2,
                              logic we, logic [4:0] wa, logic wbv, logic [4:0] wbwa,
                              logic er, logic [31:0] em, logic [7:0] et, logic ee);
    vec_t t;
    t.rst = r; t.v = v; t.u1 = u1; t.ra1 = ra1; t.u2 = u2; t.ra2 = ra2;
    t.we = we; t.wa = wa; t.wbv = wbv; t.wbwa = wbwa;
    t.e_ready = er; t.e_mask = em; t.e_total = et; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; issue_valid = t.v; issue_use1 = t.u1; issue_ra1 = t.ra1;
    issue_use2 = t.u2; issue_ra2 = t.ra2; issue_we = t.we; issue_wa = t.wa;
    wb_valid = t.wbv; wb_wa = t.wbwa;
  endtask

  task automatic idle();
    rst = 1'b0; issue_valid = 1'b0; issue_use1 = 1'b0; issue_ra1 = 5'd0;
    issue_use2 = 1'b0; issue_ra2 = 5'd0; issue_we = 1'b0; issue_wa = 5'd0;
    wb_valid = 1'b0; wb_wa = 5'd0;
  endtask

  initial begin
    int  stall;
    bit  seen;
    idle();

    //                r  v  u1 ra1   u2 ra2   we wa     wbv wbwa  rdy mask          tot  err
    // Reset
    vecs.push_back(mk(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        0,   0));
    // Writer to $8, dependent reader stalls, writeback releases one cycle later
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd8,  0, 5'd0,  1, 32'h100,      1,   0));
    vecs.push_back(mk(0, 1, 1, 5'd8, 0, 5'd0, 0, 5'd0,  0, 5'd0,  0, 32'h100,      1,   0));
    vecs.push_back(mk(0, 1, 1, 5'd8, 0, 5'd0, 0, 5'd0,  1, 5'd8,  0, 32'h0,        0,   0));
    vecs.push_back(mk(0, 1, 1, 5'd8, 0, 5'd0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        0,   0));
    // Register 0 is never tracked; wb to $0 is not an underflow
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd0,  0, 5'd0,  1, 32'h0,        0,   0));
    vecs.push_back(mk(0, 1, 1, 5'd0, 1, 5'd0, 0, 5'd0,  1, 5'd0,  1, 32'h0,        0,   0));
    // WAW saturation on $5 at MAX_OUT = 3
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5,  0, 5'd0,  1, 32'h20,       1,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5,  0, 5'd0,  1, 32'h20,       2,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5,  0, 5'd0,  1, 32'h20,       3,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5,  0, 5'd0,  0, 32'h20,       3,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5,  1, 5'd5,  0, 32'h20,       2,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5,  0, 5'd0,  1, 32'h20,       3,   0));
    // Source-2 hazard, then drain $5
    vecs.push_back(mk(0, 1, 0, 5'd0, 1, 5'd5, 0, 5'd0,  0, 5'd0,  0, 32'h20,       3,   0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  1, 5'd5,  1, 32'h20,       2,   0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  1, 5'd5,  1, 32'h20,       1,   0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  1, 5'd5,  1, 32'h0,        0,   0));
    // Simultaneous issue + wb on $9: cnt 2 stays 2; cnt 0 stays 0 and flags underflow
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd9,  0, 5'd0,  1, 32'h200,      1,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd9,  0, 5'd0,  1, 32'h200,      2,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd9,  1, 5'd9,  1, 32'h200,      2,   0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  1, 5'd9,  1, 32'h200,      1,   0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  1, 5'd9,  1, 32'h0,        0,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd9,  1, 5'd9,  1, 32'h0,        0,   1));
    vecs.push_back(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        0,   1));
    // Reset clears the sticky error
    vecs.push_back(mk(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        0,   0));
    // Underflow on $12 leaves an unrelated pending $7 untouched
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd7,  0, 5'd0,  1, 32'h80,       1,   0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  1, 5'd12, 1, 32'h80,       1,   1));
    vecs.push_back(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  0, 5'd0,  1, 32'h80,       1,   1));
    // Reset mid-flight with $3, $4, $31 pending; issue and wb during reset are ignored
    vecs.push_back(mk(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        0,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd3,  0, 5'd0,  1, 32'h8,        1,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd4,  0, 5'd0,  1, 32'h18,       2,   0));
    vecs.push_back(mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd31, 0, 5'd0,  1, 32'h80000018, 3,   0));
    vecs.push_back(mk(1, 1, 1, 5'd3, 0, 5'd0, 1, 5'd6,  1, 5'd12, 0, 32'h0,        0,   0));
    vecs.push_back(mk(0, 1, 1, 5'd3, 0, 5'd0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        0,   0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d ready", i), {31'd0, issue_ready}, {31'd0, vecs[i].e_ready});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mask", i), pending_mask, vecs[i].e_mask);
      chk($sformatf("v%0d total", i), {24'd0, total_out}, {24'd0, vecs[i].e_total});
      chk($sformatf("v%0d err", i), {31'd0, err_underflow}, {31'd0, vecs[i].e_err});
    end

    // Stall latency: writer to $10 retired 4 cycles after issue stalls the reader exactly 4 cycles.
    idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_wa = 5'd10;
    @(posedge clk);
    #1;
    idle();
    issue_valid = 1'b1; issue_use1 = 1'b1; issue_ra1 = 5'd10;
    stall = 0;
    seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      wb_valid = (c == 3);
      wb_wa    = 5'd10;
      #1;
      if (issue_ready) begin
        seen = 1'b1;
        break;
      end
      stall++;
      @(posedge clk);
      #1;
    end
    chk("stall ready seen", {31'd0, seen}, 32'd1);
    chk("stall cycles", stall, 32'd4);
    chk("stall mask after release", pending_mask, 32'h0);
    chk("stall err", {31'd0, err_underflow}, 32'd0);
    @(posedge clk);
    #1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
